// File: rtl/conv_pkg.sv
// Shared types, default widths and helpers for the signed-to-offset-binary
// DAC converter. Optional saturation counter: CONV_SIGN_TO_UNSIGN_SAT_COUNT_EN.
package conv_pkg;

    // Default geometry. The rounding offset and the code limits below follow from it.
    localparam int DEF_N_IN       = 16;
    localparam int DEF_N_OUT      = 14;
    localparam int DEF_RND_OFFSET = 1 << (DEF_N_IN - DEF_N_OUT - 1);
    localparam int DEF_R_MAX      = (1 << (DEF_N_OUT - 1)) - 1;
    localparam int DEF_R_MIN      = -(1 << (DEF_N_OUT - 1));

    // Width of a channel index. A single channel still gets one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } conv_state_t;

endpackage

// File: rtl/conv_sign_to_unsign_core.sv
// Combinational single-sample converter. It reduces a signed sample from N_IN
// to N_OUT bits with round-half-up, clips at the positive limit and flips the
// MSB to produce an offset-binary code.
module conv_sign_to_unsign_core #(
    parameter int N_IN       = 16,
    parameter int N_OUT      = 14,
    parameter int LEGACY_MID = 0
) (
    input  logic [N_IN-1:0]  x,
    output logic [N_OUT-1:0] u,
    output logic             sat
);

    localparam int SHIFT = N_IN - N_OUT;
    localparam logic signed [N_IN:0] R_MAX = {{(SHIFT + 2){1'b0}}, {(N_OUT - 1){1'b1}}};
    localparam logic [N_OUT-1:0] MIN_CODE = {1'b1, {(N_OUT - 1){1'b0}}};

    logic signed [N_IN:0] ext_s;
    logic signed [N_IN:0] shr_s;
    logic [N_OUT-1:0]     r_s;

    assign ext_s = {x[N_IN-1], x};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [N_IN:0] RND = {{N_IN{1'b0}}, 1'b1} << (SHIFT - 1);
            logic signed [N_IN:0] sum_s;
            assign sum_s = ext_s + RND;
            assign shr_s = sum_s >>> SHIFT;
        end else begin : g_noround
            assign shr_s = ext_s;
        end
    endgenerate

    // Clip to the top code, then convert to offset binary. The bottom cannot
    // clip because rounding only moves values upward.
    always_comb begin
        sat = 1'b0;
        r_s = shr_s[N_OUT-1:0];
        u   = {N_OUT{1'b0}};
        if (shr_s > R_MAX) begin
            sat = 1'b1;
            r_s = R_MAX[N_OUT-1:0];
        end else begin
            sat = 1'b0;
            r_s = shr_s[N_OUT-1:0];
        end
        if ((LEGACY_MID != 0) && (r_s == MIN_CODE)) begin
            u = MIN_CODE;
        end else begin
            u = {~r_s[N_OUT-1], r_s[N_OUT-2:0]};
        end
    end

endmodule

// File: rtl/conv_sign_to_unsign_pipe.sv
// Streaming multi-channel converter. It accepts a bundle of CHANNELS signed
// samples, converts them all at once and then plays them out one channel per
// cycle. Optional saturation event counter: CONV_SIGN_TO_UNSIGN_SAT_COUNT_EN.
module conv_sign_to_unsign_pipe
    import conv_pkg::*;
#(
    parameter int N_IN       = 16,
    parameter int N_OUT      = 14,
    parameter int CHANNELS   = 2,
    parameter int LEGACY_MID = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHANNELS*N_IN-1:0]           in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [N_OUT-1:0]                   out_data,
    output logic [clog2_min1(CHANNELS)-1:0]    out_chan,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic [15:0]                        sat_count
);

    localparam int CW = clog2_min1(CHANNELS);
    localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

    conv_state_t      state_q, state_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic [N_OUT-1:0] bundle_q [CHANNELS];
    logic [N_OUT-1:0] conv_s   [CHANNELS];
    logic [CHANNELS-1:0] sat_vec_s;
    logic             load_s;
    logic             accept_s;
    logic             out_hs_s;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            conv_sign_to_unsign_core #(
                .N_IN       (N_IN),
                .N_OUT      (N_OUT),
                .LEGACY_MID (LEGACY_MID)
            ) u_core (
                .x   (in_data[k*N_IN +: N_IN]),
                .u   (conv_s[k]),
                .sat (sat_vec_s[k])
            );
        end
    endgenerate

    assign out_valid = (state_q == SEND);
    assign out_chan  = chan_q;
    assign out_data  = bundle_q[chan_q];
    assign out_last  = out_valid && (chan_q == LAST_CHAN);
    assign in_ready  = (state_q == IDLE) || (out_ready && out_last);
    assign accept_s  = in_valid && in_ready;
    assign out_hs_s  = out_valid && out_ready;

    // Next-state logic. A new bundle is taken only while idle or on the cycle
    // that hands off the last channel, which keeps streaming gap-free.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    load_s  = 1'b1;
                    chan_d  = {CW{1'b0}};
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (out_hs_s) begin
                    if (chan_q == LAST_CHAN) begin
                        chan_d = {CW{1'b0}};
                        if (accept_s) begin
                            load_s  = 1'b1;
                            state_d = SEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        chan_d = chan_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                chan_d  = {CW{1'b0}};
            end
        endcase
    end

    // State, channel pointer and bundle registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            chan_q  <= {CW{1'b0}};
            for (int k = 0; k < CHANNELS; k++) begin
                bundle_q[k] <= {N_OUT{1'b0}};
            end
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            if (load_s) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    bundle_q[k] <= conv_s[k];
                end
            end
        end
    end

`ifdef CONV_SIGN_TO_UNSIGN_SAT_COUNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic [16:0] sat_num_s;
    logic [16:0] sat_sum_s;

    // Add this bundle's clip events to the running count, sticking at all-ones.
    always_comb begin
        sat_num_s = 17'd0;
        for (int k = 0; k < CHANNELS; k++) begin
            sat_num_s = sat_num_s + {16'd0, sat_vec_s[k]};
        end
        sat_sum_s = {1'b0, sat_cnt_q} + sat_num_s;
        if (!accept_s) begin
            sat_cnt_d = sat_cnt_q;
        end else if (sat_sum_s > 17'h0FFFF) begin
            sat_cnt_d = 16'hFFFF;
        end else begin
            sat_cnt_d = sat_sum_s[15:0];
        end
    end

    // Saturation counter register. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= 16'h0000;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    logic unused_sat_s;
    assign unused_sat_s = ^sat_vec_s;
    assign sat_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_conv_sign_to_unsign_pipe.sv
// Directed bench for conv_sign_to_unsign_pipe. It drives a normal instance and
// a LEGACY_MID=1 instance with the same stimulus.
module tb_conv_sign_to_unsign_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready,  in_ready_l;
    logic [13:0] out_data,  out_data_l;
    logic [0:0]  out_chan,  out_chan_l;
    logic        out_valid, out_valid_l;
    logic        out_last,  out_last_l;
    logic [15:0] sat_count, sat_count_l;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_sat      = 0;

    always #5 clk = ~clk;

    conv_sign_to_unsign_pipe #(.N_IN(16), .N_OUT(14), .CHANNELS(2), .LEGACY_MID(0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .sat_count(sat_count)
    );

    conv_sign_to_unsign_pipe #(.N_IN(16), .N_OUT(14), .CHANNELS(2), .LEGACY_MID(1)) dut_leg (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_data(out_data_l), .out_chan(out_chan_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l),
        .sat_count(sat_count_l)
    );

    typedef struct {
        logic [15:0] ch0;
        logic [15:0] ch1;
        logic [13:0] e0;
        logic [13:0] e1;
        logic [13:0] e1_leg;
        int          sats;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_sat_cnt();
`ifdef CONV_SIGN_TO_UNSIGN_SAT_COUNT_EN
        return (exp_sat > 65535) ? 16'hFFFF : 16'(exp_sat);
`else
        return 16'h0000;
`endif
    endfunction

    // One bundle from IDLE with out_ready high: accept, two channels, back to IDLE.
    task automatic run_bundle(input vec_t v);
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_data  = {v.ch1, v.ch0};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        exp_sat  = exp_sat + v.sats;
        chk("ch0_valid", {31'd0, out_valid}, 32'd1);
        chk("ch0_chan",  {31'd0, out_chan},  32'd0);
        chk("ch0_last",  {31'd0, out_last},  32'd0);
        chk("ch0_data",  {18'd0, out_data},  {18'd0, v.e0});
        chk("ch0_data_leg", {18'd0, out_data_l}, {18'd0, v.e0});
        chk("sat_count", {16'd0, sat_count}, {16'd0, exp_sat_cnt()});
        @(posedge clk);
        #1;
        chk("ch1_chan",  {31'd0, out_chan},  32'd1);
        chk("ch1_last",  {31'd0, out_last},  32'd1);
        chk("ch1_data",  {18'd0, out_data},  {18'd0, v.e1});
        chk("ch1_data_leg", {18'd0, out_data_l}, {18'd0, v.e1_leg});
        @(posedge clk);
        #1;
        chk("back_idle", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0006, 14'h2000, 14'h2002, 14'h2002, 0};
        vecs[1] = '{16'h7FFF, 16'h8000, 14'h3FFF, 14'h0000, 14'h2000, 1};
        vecs[2] = '{16'hFFFE, 16'hFFF9, 14'h2000, 14'h1FFE, 14'h1FFE, 0};
        vecs[3] = '{16'h7FFE, 16'h0002, 14'h3FFF, 14'h2001, 14'h2001, 1};
        vecs[4] = '{16'h0001, 16'hFFFD, 14'h2000, 14'h1FFF, 14'h1FFF, 0};
        vecs[5] = '{16'h7FFD, 16'h8002, 14'h3FFF, 14'h0001, 14'h0001, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {18'd0, out_data},  32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_chan", {31'd0, out_chan}, 32'd0);

        // Table-driven conversions, including rounding and both range ends.
        for (int i = 0; i < 6; i++) begin
            run_bundle(vecs[i]);
        end

        // Backpressure: hold at ch0 for three cycles, then release.
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = {16'h0200, 16'h0100};
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_data",     {18'd0, out_data},  32'h2040);
            chk("bp_chan",     {31'd0, out_chan},  32'd0);
            chk("bp_valid",    {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready},  32'd0);
            @(posedge clk);
            #1;
        end
        chk("bp_hold_data", {18'd0, out_data}, 32'h2040);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ch1_chan", {31'd0, out_chan}, 32'd1);
        chk("bp_ch1_data", {18'd0, out_data}, 32'h2080);
        chk("bp_ch1_last", {31'd0, out_last}, 32'd1);
        chk("bp_ch1_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_idle", {31'd0, out_valid}, 32'd0);

        // Streaming: four bundles back to back, channel value 4*v maps to 0x2000+v.
        @(negedge clk);
        in_data  = {16'(4 * 2), 16'(4 * 1)};
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("str_valid", {31'd0, out_valid}, 32'd1);
            chk("str_data", {18'd0, out_data}, {18'd0, 14'(14'h2000 + 14'(10 * (k / 2) + (k % 2) + 1))});
            chk("str_chan", {31'd0, out_chan}, 32'(k % 2));
            chk("str_in_ready", {31'd0, in_ready}, 32'(k % 2));
            if ((k % 2) == 0) begin
                if (k == 6) begin
                    in_valid = 1'b0;
                end else begin
                    in_data = {16'(4 * (10 * (k / 2 + 1) + 2)), 16'(4 * (10 * (k / 2 + 1) + 1))};
                end
            end
        end
        @(posedge clk);
        #1;
        chk("str_idle", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a bundle, then a fresh bundle.
        @(negedge clk);
        in_data  = {16'h7FFF, 16'h7FFF};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid_ch0_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sat",   {16'd0, sat_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_sat = 0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_sat",      {16'd0, sat_count}, 32'd0);
        run_bundle('{16'h0004, 16'h0008, 14'h2001, 14'h2002, 14'h2002, 0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
